// File: rtl/di_read_fifo_if.sv
// di_read_fifo_if: DI register bus between the host interface and a read endpoint
interface di_read_fifo_if;
    logic [15:0] diEpAddr;
    logic [15:0] diRegAddr;
    logic        diRead;
    logic        diReset;
    logic        rd_ready;
    logic [15:0] diRegDataOut;
    modport master(output diEpAddr, diRegAddr, diRead, diReset, input rd_ready, diRegDataOut);
    modport slave(input diEpAddr, diRegAddr, diRead, diReset, output rd_ready, diRegDataOut);
endinterface

// File: rtl/di_read_fifo.sv
// di_read_fifo: fabric-filled circular FIFO drained by the host through one DI register
module di_read_fifo #(
    parameter logic [15:0] EP_ADDR    = 16'h0000,
    parameter logic [15:0] REG_ADDR   = 16'h0000,
    parameter int          ADDR_W     = 4,
    parameter int          RDY_THRESH = 3
) (
    input  logic            if_clock,
    input  logic            resetb,
    input  logic            wr_en,
    input  logic [15:0]     wr_data,
    output logic            full,
    output logic [ADDR_W:0] fill_count,
    output logic            overflow,
    output logic            underflow,
    di_read_fifo_if.slave   di
);
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] THR      = (ADDR_W+1)'(RDY_THRESH);
    logic [15:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    logic [ADDR_W:0]   count, count_n;
    logic [15:0]       data_q;
    logic              rd_ready_q, sel, pop, push;
    assign sel             = (di.diEpAddr == EP_ADDR) && (di.diRegAddr == REG_ADDR);
    assign pop             = sel && di.diRead && (count != '0);
    assign push            = wr_en && ((count != FULL_CNT) || pop);
    assign count_n         = count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    assign full            = count == FULL_CNT;
    assign fill_count      = count;
    assign di.rd_ready     = rd_ready_q;
    assign di.diRegDataOut = sel ? data_q : 16'h0000;
    // storage array; contents need no reset, a flush only moves pointers
    always_ff @(posedge if_clock) begin
        if (push && !di.diReset) mem[wr_ptr] <= wr_data;
    end
    // pointers, occupancy, registered read data, ready prediction and sticky error flags
    always_ff @(posedge if_clock or negedge resetb) begin
        if (!resetb || di.diReset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            data_q     <= '0;
            rd_ready_q <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
                data_q <= mem[rd_ptr];
            end
            count      <= count_n;
            rd_ready_q <= sel && (count_n >= THR);
            if (wr_en && !push) overflow <= 1'b1;
            if (sel && di.diRead && count == '0) underflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_di_read_fifo.sv
// tb_di_read_fifo: directed checks of the DI read FIFO endpoint
module tb_di_read_fifo;
    logic        clk = 1'b0;
    logic        resetb, wr_en, full, overflow, underflow;
    logic [15:0] wr_data;
    logic [4:0]  fill_count;
    int          n_checks = 0;
    int          n_errors = 0;
    di_read_fifo_if bus();
    di_read_fifo dut (
        .if_clock(clk), .resetb(resetb), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .fill_count(fill_count), .overflow(overflow), .underflow(underflow), .di(bus)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    initial begin
        resetb = 1'b0; wr_en = 1'b0; wr_data = '0;
        bus.diEpAddr = 16'h0000; bus.diRegAddr = 16'h0001; bus.diRead = 1'b0; bus.diReset = 1'b0;
        repeat (2) tick();
        resetb = 1'b1;
        tick();
        check("init_cnt", fill_count, 0);
        check("init_rdy", bus.rd_ready, 0);
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 16'(16'h0010 + i); tick();
        end
        wr_en = 1'b0; bus.diRegAddr = 16'h0000; bus.diRead = 1'b1; tick();
        bus.diRead = 1'b0;
        check("pre_rst_cnt", fill_count, 5);
        check("pre_rst_data", bus.diRegDataOut, 16'h0010);
        check("pre_rst_rdy", bus.rd_ready, 1);
        resetb = 1'b0; #1;
        check("rst_cnt", fill_count, 0);
        check("rst_rdy", bus.rd_ready, 0);
        check("rst_data", bus.diRegDataOut, 0);
        check("rst_full", full, 0);
        check("rst_flags", {overflow, underflow}, 0);
        tick(); resetb = 1'b1; tick();
        check("post_rst_cnt", fill_count, 0);
        check("post_rst_rdy", bus.rd_ready, 0);
        bus.diRegAddr = 16'h0001;
        for (int i = 1; i <= 4; i++) begin
            wr_en = 1'b1; wr_data = 16'(i); tick();
        end
        wr_en = 1'b0;
        check("unsel_cnt", fill_count, 4);
        check("unsel_rdy", bus.rd_ready, 0);
        check("unsel_mask", bus.diRegDataOut, 0);
        bus.diRegAddr = 16'h0000; tick();
        check("sel_rdy", bus.rd_ready, 1);
        bus.diRead = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("burst_data", bus.diRegDataOut, k);
        end
        bus.diRead = 1'b0;
        check("burst_cnt", fill_count, 0);
        check("burst_uf", underflow, 0);
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_data = 16'(16'h0100 + i); tick();
        end
        wr_en = 1'b0;
        check("fill_full", full, 1);
        check("fill_cnt", fill_count, 16);
        check("fill_ov", overflow, 0);
        wr_en = 1'b1; wr_data = 16'hBEEF; tick();
        wr_en = 1'b0;
        check("drop_ov", overflow, 1);
        check("drop_cnt", fill_count, 16);
        wr_en = 1'b1; wr_data = 16'hCAFE; bus.diRead = 1'b1; tick();
        wr_en = 1'b0;
        check("pp_data", bus.diRegDataOut, 16'h0100);
        check("pp_cnt", fill_count, 16);
        for (int i = 1; i < 16; i++) begin
            tick();
            check("drain_data", bus.diRegDataOut, 16'h0100 + i);
        end
        tick();
        check("drain_last", bus.diRegDataOut, 16'hCAFE);
        bus.diRead = 1'b0;
        check("drain_cnt", fill_count, 0);
        check("drain_uf", underflow, 0);
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_data = 16'(16'h0031 + i); tick();
        end
        wr_en = 1'b0;
        check("thr_rdy", bus.rd_ready, 1);
        bus.diRead = 1'b1;
        tick();
        check("thr_fall", bus.rd_ready, 0);
        check("thr_d1", bus.diRegDataOut, 16'h0031);
        tick();
        check("thr_d2", bus.diRegDataOut, 16'h0032);
        check("thr_uf2", underflow, 0);
        tick();
        check("thr_d3", bus.diRegDataOut, 16'h0033);
        check("thr_uf3", underflow, 0);
        check("thr_cnt", fill_count, 0);
        tick();
        check("uf_flag", underflow, 1);
        check("uf_hold", bus.diRegDataOut, 16'h0033);
        check("uf_cnt", fill_count, 0);
        bus.diRead = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 16'(16'h0500 + i); tick();
        end
        bus.diRead = 1'b1;
        for (int k = 0; k < 40; k++) begin
            wr_data = 16'(16'h0600 + k); tick();
            check("wrap_data", bus.diRegDataOut, k < 4 ? 32'h0500 + k : 32'h0600 + k - 4);
            check("wrap_cnt", fill_count, 4);
        end
        bus.diRead = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_data = 16'(16'h0700 + i); tick();
        end
        check("pre_flush_cnt", fill_count, 7);
        bus.diReset = 1'b1; bus.diRead = 1'b1; wr_data = 16'h0999; tick();
        bus.diReset = 1'b0; bus.diRead = 1'b0; wr_en = 1'b0;
        check("flush_cnt", fill_count, 0);
        check("flush_rdy", bus.rd_ready, 0);
        check("flush_flags", {overflow, underflow}, 0);
        check("flush_data", bus.diRegDataOut, 0);
        wr_en = 1'b1; wr_data = 16'h0077; tick();
        wr_en = 1'b0; bus.diRead = 1'b1; tick();
        bus.diRead = 1'b0;
        check("post_flush_data", bus.diRegDataOut, 16'h0077);
        check("post_flush_cnt", fill_count, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
